// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 64;
    // Widest operand the sign helper supports; narrower operands are zero-extended into it.
    localparam int DIV_MAX_WIDTH     = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Two's-complement negate when requested; callers truncate back to their own width.
    function automatic logic [DIV_MAX_WIDTH-1:0] div_cond_negate(
        input logic [DIV_MAX_WIDTH-1:0] value,
        input logic                     negate
    );
        logic [DIV_MAX_WIDTH-1:0] result;
        if (negate) begin
            result = ~value + {{(DIV_MAX_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left, trial subtract, select.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;
    logic           fits_s;

    // Shifted remainder is < 2*divisor, so the WIDTH+1-bit difference never overflows its sign bit.
    always_comb begin
        shifted_s = {rem, quo[WIDTH-1]};
        trial_s   = shifted_s + ~{1'b0, divisor_mag} + {{WIDTH{1'b0}}, 1'b1};
        fits_s    = ~trial_s[WIDTH];
        if (fits_s) begin
            next_rem = trial_s[WIDTH-1:0];
        end else begin
            next_rem = shifted_s[WIDTH-1:0];
        end
        next_quo = {quo[WIDTH-2:0], fits_s};
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider producing quotient and remainder, unsigned or signed.
// Define SEQ_DIVIDER_EARLY_OUT_EN to take the two-cycle short path whenever |dividend| < |divisor|.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ZERO_HOLD = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    div_state_t       state_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] divisor_mag_r;
    logic [WIDTH-1:0] dividend_r;
    logic             neg_quo_r;
    logic             neg_rem_r;
    logic             divisor_zero_r;

    logic             dividend_neg_s;
    logic             divisor_neg_s;
    logic [WIDTH-1:0] dividend_mag_s;
    logic [WIDTH-1:0] divisor_mag_s;
    logic             divisor_zero_s;
    logic             short_path_s;
    logic [WIDTH-1:0] next_rem_s;
    logic [WIDTH-1:0] next_quo_s;
    logic [WIDTH-1:0] quo_fixed_s;
    logic [WIDTH-1:0] rem_fixed_s;

    // Operand magnitudes and the short-path decision, evaluated on the live inputs at capture
    always_comb begin
        dividend_neg_s = signed_op & dividend[WIDTH-1];
        divisor_neg_s  = signed_op & divisor[WIDTH-1];
        dividend_mag_s = WIDTH'(div_cond_negate(DIV_MAX_WIDTH'(dividend), dividend_neg_s));
        divisor_mag_s  = WIDTH'(div_cond_negate(DIV_MAX_WIDTH'(divisor), divisor_neg_s));
        divisor_zero_s = (divisor == {WIDTH{1'b0}});
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        if (divisor_zero_s || (dividend_mag_s < divisor_mag_s)) begin
            short_path_s = 1'b1;
        end else begin
            short_path_s = 1'b0;
        end
`else
        short_path_s = divisor_zero_s;
`endif
    end

    // Sign fixup applied to the final magnitudes
    always_comb begin
        quo_fixed_s = WIDTH'(div_cond_negate(DIV_MAX_WIDTH'(quo_r), neg_quo_r));
        rem_fixed_s = WIDTH'(div_cond_negate(DIV_MAX_WIDTH'(rem_r), neg_rem_r));
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem        (rem_r),
        .quo        (quo_r),
        .divisor_mag(divisor_mag_r),
        .next_rem   (next_rem_s),
        .next_quo   (next_quo_s)
    );

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            count_r        <= {CNT_W{1'b0}};
            rem_r          <= {WIDTH{1'b0}};
            quo_r          <= {WIDTH{1'b0}};
            divisor_mag_r  <= {WIDTH{1'b0}};
            dividend_r     <= {WIDTH{1'b0}};
            neg_quo_r      <= 1'b0;
            neg_rem_r      <= 1'b0;
            divisor_zero_r <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            quotient       <= {WIDTH{1'b0}};
            remainder      <= {WIDTH{1'b0}};
            div_by_zero    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        rem_r          <= {WIDTH{1'b0}};
                        quo_r          <= dividend_mag_s;
                        divisor_mag_r  <= divisor_mag_s;
                        dividend_r     <= dividend;
                        neg_quo_r      <= dividend_neg_s ^ divisor_neg_s;
                        neg_rem_r      <= dividend_neg_s;
                        divisor_zero_r <= divisor_zero_s;
                        count_r        <= {CNT_W{1'b0}};
                        busy           <= 1'b1;
                        state_r        <= short_path_s ? ZERO : RUN;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                // Short path: held two cycles so its latency is fixed regardless of cause
                ZERO: begin
                    if (count_r == ZERO_HOLD) begin
                        quotient    <= {WIDTH{1'b0}};
                        remainder   <= dividend_r;
                        div_by_zero <= divisor_zero_r;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state_r     <= DONE;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                RUN: begin
                    if (count_r == LAST_STEP) begin
                        quotient    <= quo_fixed_s;
                        remainder   <= rem_fixed_s;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state_r     <= DONE;
                    end else begin
                        rem_r   <= next_rem_s;
                        quo_r   <= next_quo_s;
                        count_r <= count_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed, table-driven bench for seq_divider plus handshake and reset sequences.
module tb_seq_divider;

    localparam int W = 64;
    localparam int TIMEOUT = 200;
    localparam int NVEC = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int tests_run = 0;
    int tests_failed = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%0b required=%0b", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input vec_t v);
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        ma = (v.s && v.a[W-1]) ? -v.a : v.a;
        mb = (v.s && v.b[W-1]) ? -v.b : v.b;
        if (ma < mb) return 2;
`endif
        if (v.b == '0) return 2;
        return W + 1;
    endfunction

    // Present operands with start high, let edge 0 sample them, then drop start.
    task automatic launch_now(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count edges after edge 0 until done is seen; optionally pulse start at edge inject_at.
    task automatic wait_done(input int inject_at, input logic [W-1:0] ia, input logic [W-1:0] ib,
                             output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < TIMEOUT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) check1("busy_after_start", busy, 1'b1);
            if (done) begin
                got = 1'b1;
            end else if (lat == inject_at) begin
                start    = 1'b1;
                dividend = ia;
                divisor  = ib;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!got) check1("done_timeout", done, 1'b1);
    endtask

    initial begin
        int lat;
        logic [W-1:0] held_q;

        vecs[0]  = '{64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[2]  = '{64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0};
        vecs[3]  = '{64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[4]  = '{64'h1234, 64'd0, 1'b0, 64'd0, 64'h1234, 1'b1};
        vecs[5]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1};
        vecs[6]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 1'b0};
        vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
        vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0};
        vecs[9]  = '{64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b0, 64'd2635249153387078788, 64'd0, 1'b0};
        vecs[10] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 64'h8000_0000_0000_0000, 1'b0};
        vecs[11] = '{64'd3, 64'd7, 1'b0, 64'd0, 64'd3, 1'b0};
        vecs[12] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[13] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 1'b0};
        vecs[14] = '{64'd1000, 64'd1000, 1'b1, 64'd1, 64'd0, 1'b0};
        vecs[15] = '{64'd0, 64'd5, 1'b0, 64'd0, 64'd0, 1'b0};

        reset = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);
        check("reset_quotient", quotient, '0);
        check("reset_remainder", remainder, '0);
        check1("reset_dbz", div_by_zero, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            launch_now(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_done(0, '0, '0, lat);
            check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
            check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
            check1($sformatf("v%0d_div_by_zero", i), div_by_zero, vecs[i].z);
            check1($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
            check($sformatf("v%0d_latency", i), W'(lat), W'(exp_latency(vecs[i])));
            held_q = quotient;
            @(negedge clk);
            check1($sformatf("v%0d_done_pulse", i), done, 1'b0);
            check($sformatf("v%0d_quotient_held", i), quotient, vecs[i].q);
        end

        // start mid-RUN with new operands is ignored
        @(negedge clk);
        launch_now(64'd100, 64'd7, 1'b0);
        wait_done(10, 64'd9, 64'd3, lat);
        check("midrun_quotient", quotient, 64'd14);
        check("midrun_remainder", remainder, 64'd2);
        check("midrun_latency", W'(lat), W'(W + 1));

        // back-to-back: start in the DONE cycle is accepted immediately
        @(negedge clk);
        launch_now(64'd100, 64'd7, 1'b0);
        wait_done(0, '0, '0, lat);
        check("b2b_first_quotient", quotient, 64'd14);
        launch_now(64'd9, 64'd3, 1'b0);
        @(negedge clk);
        check1("b2b_busy", busy, 1'b1);
        check1("b2b_done_low", done, 1'b0);
        wait_done(0, '0, '0, lat);
        check("b2b_quotient", quotient, 64'd3);
        check("b2b_remainder", remainder, 64'd0);
        check("b2b_latency", W'(lat), W'(W + 1));

        // reset mid-RUN abandons the divide; start during reset is ignored
        @(negedge clk);
        launch_now(64'd100, 64'd7, 1'b0);
        repeat (29) @(posedge clk);
        @(negedge clk);
        check1("pre_reset_busy", busy, 1'b1);
        reset = 1'b1; start = 1'b1; dividend = 64'd5; divisor = 64'd1;
        @(posedge clk);
        @(negedge clk);
        check1("midreset_busy", busy, 1'b0);
        check1("midreset_done", done, 1'b0);
        check("midreset_quotient", quotient, '0);
        check("midreset_remainder", remainder, '0);
        check1("midreset_dbz", div_by_zero, 1'b0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check1("post_reset_idle", busy, 1'b0);
        launch_now(64'd9, 64'd3, 1'b0);
        wait_done(0, '0, '0, lat);
        check("post_reset_quotient", quotient, 64'd3);
        check("post_reset_remainder", remainder, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
